// File: rtl/vga_status_reader_pkg.sv
// vga_status_reader_pkg: VGA timing constants and status register offsets.
package vga_status_reader_pkg;
  localparam logic [15:0] H_VIS_FIRST = 16'd144;
  localparam logic [15:0] H_VIS_LAST  = 16'd783;
  localparam logic [15:0] H_SYNC      = 16'd96;
  localparam logic [15:0] H_TOTAL     = 16'd800;
  localparam logic [15:0] V_VIS_FIRST = 16'd35;
  localparam logic [15:0] V_VIS_LAST  = 16'd514;
  localparam logic [15:0] V_SYNC      = 16'd2;
  localparam logic [15:0] V_TOTAL     = 16'd525;
  localparam logic [11:0] OFF_STATUS  = 12'd0;
  localparam logic [11:0] OFF_LINE    = 12'd1;
  localparam logic [11:0] OFF_FRAME   = 12'd2;
  localparam logic [11:0] OFF_COLUMN  = 12'd3;
  localparam logic [11:0] OFF_CTRL    = 12'd4;
endpackage

// File: rtl/vga_status_reader_event_detect.sv
// vga_event_detect: registers v_count and flags vblank entry and frame start from value changes.
module vga_event_detect
  import vga_status_reader_pkg::*;
#(
  parameter logic [15:0] V_LAST = V_VIS_LAST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] v_count,
  output logic [15:0] v_prev,
  output logic        vblank_entry,
  output logic        frame_start
);
  logic [15:0] v_prev_q, v_prev_d;
  always_comb begin
    v_prev_d = v_count;
  end
  always_ff @(posedge clk) begin
    if (rst) v_prev_q <= '0;
    else     v_prev_q <= v_prev_d;
  end
  assign v_prev       = v_prev_q;
  assign vblank_entry = (v_prev_q == V_LAST) && (v_count == V_LAST + 16'd1);
  assign frame_start  = (v_prev_q != '0) && (v_count == '0);
endmodule

// File: rtl/vga_status_reader.sv
// vga_status_reader: CPU read responder for VGA scan position, blanking, frame count and vblank events.
// Define VGA_STATUS_IRQ_EN to enable the CTRL irq_en bit and the registered vblank irq.
module vga_status_reader
  import vga_status_reader_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'h001,
  parameter logic [15:0] V_FIRST   = V_VIS_FIRST,
  parameter logic [15:0] V_LAST    = V_VIS_LAST,
  parameter logic [15:0] H_FIRST   = H_VIS_FIRST,
  parameter logic [15:0] H_LAST    = H_VIS_LAST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] h_count,
  input  logic [15:0] v_count,
  input  logic        read,
  input  logic        write,
  input  logic [11:0] address,
  input  logic [11:0] data,
  output logic [11:0] read_data,
  output logic        read_valid,
  output logic        irq
);
  logic [15:0] v_prev;
  logic        vblank_entry, frame_start, in_vblank, in_hblank;
  logic [11:0] off, rd_mux, status;
  logic        status_rd, frame_wr;
  logic [11:0] frame_cnt_q, frame_cnt_d, read_data_q, read_data_d;
  logic        sticky_q, sticky_d, overrun_q, overrun_d, read_valid_q, read_valid_d;
  logic        irq_en_q;
  vga_event_detect #(.V_LAST(V_LAST)) u_evt (
    .clk          (clk),
    .rst          (rst),
    .v_count      (v_count),
    .v_prev       (v_prev),
    .vblank_entry (vblank_entry),
    .frame_start  (frame_start)
  );
  assign in_vblank = (v_count < V_FIRST) || (v_count > V_LAST);
  assign in_hblank = (h_count < H_FIRST) || (h_count > H_LAST);
  assign off       = address - BASE_ADDR;
  assign status    = {8'b0, overrun_q, sticky_q, in_hblank, in_vblank};
  assign status_rd = read && (off == OFF_STATUS);
  assign frame_wr  = write && (off == OFF_FRAME);
  always_comb begin
    rd_mux = off == OFF_STATUS ? status :
             off == OFF_LINE   ? v_count[11:0] :
             off == OFF_FRAME  ? frame_cnt_q :
             off == OFF_COLUMN ? h_count[11:0] :
             off == OFF_CTRL   ? {11'b0, irq_en_q} : 12'h000;
    // Event sets take priority over the read-to-clear; the read returns pre-update flags.
    sticky_d     = vblank_entry ? 1'b1 : status_rd ? 1'b0 : sticky_q;
    overrun_d    = (vblank_entry && sticky_q) ? 1'b1 : status_rd ? 1'b0 : overrun_q;
    frame_cnt_d  = frame_wr ? data : frame_start ? frame_cnt_q + 12'd1 : frame_cnt_q;
    read_data_d  = read ? rd_mux : read_data_q;
    read_valid_d = read;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q     <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      sticky_q     <= sticky_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end
`ifdef VGA_STATUS_IRQ_EN
  logic irq_en_d, irq_q, irq_d;
  always_comb begin
    irq_en_d = (write && (off == OFF_CTRL)) ? data[0] : irq_en_q;
    irq_d    = irq_en_q & sticky_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
endmodule

// File: tb/tb_vga_status_reader.sv
// tb_vga_status_reader: directed self-checking bench for vga_status_reader.
module tb_vga_status_reader;
`ifdef VGA_STATUS_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [11:0] A_STATUS = 12'h001;
  localparam logic [11:0] A_LINE   = 12'h002;
  localparam logic [11:0] A_FRAME  = 12'h003;
  localparam logic [11:0] A_COLUMN = 12'h004;
  localparam logic [11:0] A_CTRL   = 12'h005;
  logic        clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0;
  logic [15:0] h_count = 16'd50, v_count = 16'd100;
  logic [11:0] address = '0, data = '0, read_data;
  logic        read_valid, irq;
  int checks = 0, errors = 0;
  vga_status_reader dut (
    .clk        (clk),
    .rst        (rst),
    .h_count    (h_count),
    .v_count    (v_count),
    .read       (read),
    .write      (write),
    .address    (address),
    .data       (data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .irq        (irq)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [11:0] addr, input logic [11:0] exp);
    address = addr;
    read = 1'b1;
    tick;
    read = 1'b0;
    check({tag, "_valid"}, {11'b0, read_valid}, 12'h001);
    check(tag, read_data, exp);
  endtask
  task automatic wr(input logic [11:0] addr, input logic [11:0] d);
    address = addr;
    data = d;
    write = 1'b1;
    tick;
    write = 1'b0;
  endtask
  task automatic set_v(input logic [15:0] v);
    v_count = v;
    tick;
  endtask
  initial begin
    tick;
    tick;
    rst = 1'b0;
    check("rst_valid", {11'b0, read_valid}, 12'h000);
    check("rst_data", read_data, 12'h000);
    check("rst_irq", {11'b0, irq}, 12'h000);
    rd("status_vis", A_STATUS, 12'h002);
    tick;
    check("valid_one_cycle", {11'b0, read_valid}, 12'h000);
    check("data_hold", read_data, 12'h002);
    h_count = 16'd200;
    set_v(16'd514);
    set_v(16'd515);
    rd("status_entry", A_STATUS, 12'h005);
    rd("status_cleared", A_STATUS, 12'h001);
    set_v(16'd514);
    set_v(16'd515);
    set_v(16'd514);
    set_v(16'd515);
    rd("status_overrun", A_STATUS, 12'h00D);
    rd("status_ovr_clr", A_STATUS, 12'h001);
    for (int i = 0; i < 3; i++) begin
      set_v(16'd524);
      set_v(16'd0);
    end
    rd("frame_3", A_FRAME, 12'h003);
    wr(A_FRAME, 12'hFFF);
    check("write_no_valid", {11'b0, read_valid}, 12'h000);
    rd("frame_fff", A_FRAME, 12'hFFF);
    set_v(16'd524);
    set_v(16'd0);
    rd("frame_wrap", A_FRAME, 12'h000);
    set_v(16'd524);
    v_count = 16'd0;
    wr(A_FRAME, 12'h123);
    rd("frame_write_wins", A_FRAME, 12'h123);
    set_v(16'd514);
    v_count = 16'd515;
    rd("status_same_cycle", A_STATUS, 12'h001);
    rd("status_after_same", A_STATUS, 12'h005);
    rd("status_clr2", A_STATUS, 12'h001);
    rd("line", A_LINE, 12'h203);
    rd("column", A_COLUMN, 12'h0C8);
    rd("unmapped_hi", 12'h006, 12'h000);
    rd("unmapped_lo", 12'h000, 12'h000);
    wr(A_LINE, 12'h777);
    rd("line_ro", A_LINE, 12'h203);
    address = A_FRAME;
    data = 12'h456;
    read = 1'b1;
    write = 1'b1;
    tick;
    read = 1'b0;
    write = 1'b0;
    check("rdwr_old", read_data, 12'h123);
    rd("rdwr_new", A_FRAME, 12'h456);
    wr(A_CTRL, 12'h001);
    rd("ctrl", A_CTRL, {11'b0, IRQ});
    set_v(16'd514);
    set_v(16'd515);
    check("irq_lag", {11'b0, irq}, 12'h000);
    tick;
    check("irq_rise", {11'b0, irq}, {11'b0, IRQ});
    rd("status_irq", A_STATUS, 12'h005);
    check("irq_hold", {11'b0, irq}, {11'b0, IRQ});
    tick;
    check("irq_drop", {11'b0, irq}, 12'h000);
    address = A_STATUS;
    read = 1'b1;
    rst = 1'b1;
    tick;
    read = 1'b0;
    rst = 1'b0;
    check("rst_cancel_valid", {11'b0, read_valid}, 12'h000);
    check("rst_cancel_data", read_data, 12'h000);
    rd("frame_after_rst", A_FRAME, 12'h000);
    rd("ctrl_after_rst", A_CTRL, 12'h000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
